// File: rtl/cgra_config_mem_responder.sv
// rtl/cgra_config_mem_responder.sv - configuration bitstream memory answering loader frame reads
//
// Purpose:
//   Holds DEPTH configuration frames that the host/DMA writes through a simple
//   write port. It serves one frame per loader request after READ_LATENCY
//   cycles (legal range 1..15), so loader sequencing sees realistic memory
//   timing. Out-of-range requests still get a response, with zero data, and
//   they set a sticky error flag.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   wr_en         host write strobe; writes wr_data to word wr_addr at the edge
//   wr_addr       host write word index
//   wr_data       host write data
//   mem_addr      loader read address; BASE_ADDR maps to word 0
//   mem_read      loader read request (level), sampled only while idle
//   mem_rdata     returned frame; holds its last value between responses
//   mem_valid     one-cycle response strobe
//   busy          request in flight (waiting or responding)
//   rd_count      responses issued, wrapping at 16 bits
//   addr_error    sticky out-of-range flag
//   err_clear     clears addr_error; a same-edge set takes priority

module cgra_config_mem_responder #(
  parameter int CONFIG_WIDTH = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [CONFIG_WIDTH-1:0]  wr_data,
  input  logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic                     mem_read,
  output logic [CONFIG_WIDTH-1:0]  mem_rdata,
  output logic                     mem_valid,
  output logic                     busy,
  output logic [15:0]              rd_count,
  output logic                     addr_error,
  input  logic                     err_clear
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0]            LAT_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

  // Frame storage is deliberately not reset so contents survive rst.
  logic [CONFIG_WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [CONFIG_WIDTH-1:0] data_q, data_d;
  logic [CONFIG_WIDTH-1:0] rdata_q, rdata_d;
  logic [15:0]             rd_count_q, rd_count_d;
  logic                    addr_error_q, addr_error_d;

  logic [ADDR_WIDTH-1:0]   offset;
  logic                    in_range;
  logic [CONFIG_WIDTH-1:0] cap_data;

  // The host write lands at the edge. The capture in the state logic samples
  // the array before that edge, so a same-edge write and capture to one word
  // returns the old frame.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Modular subtract: an address below BASE_ADDR wraps to a large offset and
  // is reported as out of range.
  always_comb begin
    offset   = mem_addr - BASE_ADDR;
    in_range = (offset < DEPTH_A);
    cap_data = in_range ? mem_q[offset[IDX_W-1:0]] : '0;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    rd_count_d   = rd_count_q;
    addr_error_d = addr_error_q;

    if (err_clear) begin
      addr_error_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (mem_read) begin
          data_d = cap_data;
          cnt_d  = LAT_LOAD;
          if (!in_range) begin
            addr_error_d = 1'b1;
          end
          if (READ_LATENCY == 1) begin
            state_d = ST_RESP;
            rdata_d = cap_data;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      // The counter reaches zero on the same edge that enters RESP. That
      // places mem_valid exactly READ_LATENCY cycles after the capture edge.
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
          rdata_d = data_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      // Always return to IDLE for one cycle, so the loader's next address has
      // settled before it is sampled.
      ST_RESP: begin
        rd_count_d = rd_count_q + 16'd1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      data_q       <= '0;
      rdata_q      <= '0;
      rd_count_q   <= 16'd0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      rd_count_q   <= rd_count_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_valid  = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign rd_count   = rd_count_q;
  assign addr_error = addr_error_q;

endmodule

// File: tb/tb_cgra_config_mem_responder.sv
// tb/tb_cgra_config_mem_responder.sv - self-checking bench for cgra_config_mem_responder

module tb_cgra_config_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam int          DEP  = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        err_clear = 1'b0;

  logic [31:0] mem_addr = '0;
  logic        mem_read = 1'b0;
  logic [63:0] mem_rdata;
  logic        mem_valid, busy, addr_error;
  logic [15:0] rd_count;

  logic [31:0] mem_addr1 = '0;
  logic        mem_read1 = 1'b0;
  logic [63:0] mem_rdata1;
  logic        mem_valid1, busy1, addr_error1;
  logic [15:0] rd_count1;

  int checks = 0;
  int failures = 0;

  // Reference model: frame contents, which words hold known data, expected counters.
  logic [63:0] model_mem [DEP];
  bit          written [DEP];
  int          exp_count = 0;
  bit          exp_err = 1'b0;

  always #5 clk = ~clk;

  cgra_config_mem_responder #(
    .CONFIG_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(DEP), .READ_LATENCY(2), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .busy(busy), .rd_count(rd_count), .addr_error(addr_error), .err_clear(err_clear)
  );

  cgra_config_mem_responder #(
    .CONFIG_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(DEP), .READ_LATENCY(1), .BASE_ADDR(BASE)
  ) dut_l1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr1), .mem_read(mem_read1), .mem_rdata(mem_rdata1), .mem_valid(mem_valid1),
    .busy(busy1), .rd_count(rd_count1), .addr_error(addr_error1), .err_clear(1'b0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    model_mem[a] = d;
    written[a] = 1'b1;
  endtask

  // Issues one request from IDLE. The task only observes; callers do the checks.
  // lat is the number of edges from capture to the valid cycle, or -1 on timeout.
  task automatic issue_read(input logic [31:0] addr, input bit do_wr, input logic [7:0] waddr,
                            input logic [63:0] wdata, input bit clr, output int lat,
                            output logic [63:0] data, output logic err);
    mem_addr = addr; mem_read = 1'b1;
    wr_en = do_wr; wr_addr = waddr; wr_data = wdata; err_clear = clr;
    step();
    mem_read = 1'b0; wr_en = 1'b0; err_clear = 1'b0;
    mem_addr = $urandom;
    lat = 1;
    while (!mem_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!mem_valid) lat = -1;
    data = mem_rdata;
    err  = addr_error;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", mem_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rd_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", rd_count); end
    checks++; if (addr_error !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", addr_error); end
    checks++; if (mem_rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata); end
    checks++; if ({mem_valid1, busy1, addr_error1, rd_count1} !== 19'd0) begin
      failures++; $display("FAIL reset_l1 got=%b/%b/%b/%0d exp=0", mem_valid1, busy1, addr_error1, rd_count1);
    end
    rst = 1'b0;
    exp_count = 0; exp_err = 1'b0;
  endtask

  task automatic test_burst();
    int cyc, last, beats;
    for (int i = 0; i < 16; i++) host_write(8'(i), 64'hA5A5_0000_0000_0000 + 64'(i));
    mem_read = 1'b1; mem_addr = BASE;
    cyc = 0; last = 0; beats = 0;
    while (beats < 16 && cyc < 200) begin
      step();
      cyc++;
      if (mem_valid) begin
        checks++; if (mem_rdata !== model_mem[beats]) begin
          failures++; $display("FAIL burst_data beat=%0d got=%h exp=%h", beats, mem_rdata, model_mem[beats]);
        end
        if (beats > 0) begin
          checks++; if (cyc - last !== 3) begin
            failures++; $display("FAIL burst_spacing beat=%0d got=%0d exp=3", beats, cyc - last);
          end
        end
        last = cyc;
        beats++;
        exp_count++;
        mem_addr = BASE + 32'(beats);
      end
    end
    mem_read = 1'b0;
    step();
    checks++; if (beats !== 16) begin failures++; $display("FAIL burst_beats got=%0d exp=16", beats); end
    checks++; if (rd_count !== 16'(exp_count)) begin failures++; $display("FAIL burst_count got=%0d exp=%0d", rd_count, exp_count); end
  endtask

  task automatic test_latency();
    bit exp_v [4] = '{0, 1, 0, 0};
    bit exp_b [4] = '{1, 1, 0, 0};
    mem_addr = BASE + 32'd9; mem_read = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      mem_read = 1'b0;
      checks++; if (mem_valid !== exp_v[c] || busy !== exp_b[c]) begin
        failures++; $display("FAIL latency2 cyc=%0d got=%b/%b exp=%b/%b", c, mem_valid, busy, exp_v[c], exp_b[c]);
      end
      if (exp_v[c]) begin
        checks++; if (mem_rdata !== model_mem[9]) begin failures++; $display("FAIL latency2_data got=%h exp=%h", mem_rdata, model_mem[9]); end
      end
    end
    exp_count++;
    checks++; if (rd_count !== 16'(exp_count)) begin failures++; $display("FAIL latency2_count got=%0d exp=%0d", rd_count, exp_count); end
  endtask

  task automatic test_latency_rl1();
    bit exp_v [3] = '{1, 0, 0};
    mem_addr1 = BASE + 32'd2; mem_read1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      mem_read1 = 1'b0;
      checks++; if (mem_valid1 !== exp_v[c] || busy1 !== exp_v[c]) begin
        failures++; $display("FAIL latency1 cyc=%0d got=%b/%b exp=%b/%b", c, mem_valid1, busy1, exp_v[c], exp_v[c]);
      end
      if (exp_v[c]) begin
        checks++; if (mem_rdata1 !== model_mem[2]) begin failures++; $display("FAIL latency1_data got=%h exp=%h", mem_rdata1, model_mem[2]); end
      end
    end
    checks++; if (rd_count1 !== 16'd1 || addr_error1 !== 1'b0) begin
      failures++; $display("FAIL latency1_count got=%0d/%b exp=1/0", rd_count1, addr_error1);
    end
  endtask

  task automatic test_drop_read();
    int beats = 0;
    mem_addr = BASE + 32'd5; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    if (mem_valid) beats++;
    for (int c = 0; c < 8; c++) begin
      step();
      if (mem_valid) begin
        beats++;
        checks++; if (mem_rdata !== model_mem[5]) begin failures++; $display("FAIL drop_data got=%h exp=%h", mem_rdata, model_mem[5]); end
      end
    end
    exp_count++;
    checks++; if (beats !== 1) begin failures++; $display("FAIL drop_beats got=%0d exp=1", beats); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_busy got=%b exp=0", busy); end
    checks++; if (rd_count !== 16'(exp_count)) begin failures++; $display("FAIL drop_count got=%0d exp=%0d", rd_count, exp_count); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [63:0] d; logic e;
    issue_read(BASE + 32'(DEP), 1'b0, 8'd0, 64'd0, 1'b0, lat, d, e);
    exp_count++; exp_err = 1'b1;
    checks++; if (lat !== 2) begin failures++; $display("FAIL oor_latency got=%0d exp=2", lat); end
    checks++; if (d !== 64'd0) begin failures++; $display("FAIL oor_data got=%h exp=0", d); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", e); end
    step(); step(); step();
    checks++; if (addr_error !== 1'b1) begin failures++; $display("FAIL oor_sticky got=%b exp=1", addr_error); end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    exp_err = 1'b0;
    checks++; if (addr_error !== 1'b0) begin failures++; $display("FAIL oor_clear got=%b exp=0", addr_error); end
    issue_read(BASE + 32'd300, 1'b0, 8'd0, 64'd0, 1'b1, lat, d, e);
    exp_count++; exp_err = 1'b1;
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_set_wins got=%b exp=1", e); end
    issue_read(BASE - 32'd1, 1'b0, 8'd0, 64'd0, 1'b0, lat, d, e);
    exp_count++;
    checks++; if (d !== 64'd0 || lat !== 2) begin failures++; $display("FAIL oor_below got=%h/%0d exp=0/2", d, lat); end
    checks++; if (rd_count !== 16'(exp_count)) begin failures++; $display("FAIL oor_count got=%0d exp=%0d", rd_count, exp_count); end
  endtask

  task automatic test_read_before_write();
    int lat; logic [63:0] d; logic e;
    host_write(8'd5, 64'h11);
    issue_read(BASE + 32'd5, 1'b1, 8'd5, 64'h22, 1'b0, lat, d, e);
    exp_count++;
    checks++; if (d !== 64'h11) begin failures++; $display("FAIL rbw_old got=%h exp=11", d); end
    model_mem[5] = 64'h22;
    issue_read(BASE + 32'd5, 1'b0, 8'd0, 64'd0, 1'b0, lat, d, e);
    exp_count++;
    checks++; if (d !== 64'h22) begin failures++; $display("FAIL rbw_new got=%h exp=22", d); end
    // A write during the wait must not change the captured frame.
    mem_addr = BASE + 32'd7; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 64'hDEAD_BEEF;
    step();
    wr_en = 1'b0;
    checks++; if (mem_valid !== 1'b1 || mem_rdata !== model_mem[7]) begin
      failures++; $display("FAIL inflight_write got=%b/%h exp=1/%h", mem_valid, mem_rdata, model_mem[7]);
    end
    model_mem[7] = 64'hDEAD_BEEF;
    step();
    exp_count++;
  endtask

  task automatic test_random();
    int lat; logic [63:0] d; logic e;
    logic [63:0] exp_d; logic [31:0] addr; int idx; bit oor; bit cw; bit clr;
    logic [7:0] waddr; logic [63:0] wdata;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) host_write(8'($urandom_range(0, 31)), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        err_clear = 1'b1; step(); err_clear = 1'b0; exp_err = 1'b0;
      end
      oor = ($urandom_range(0, 4) == 0);
      idx = $urandom_range(0, 31);
      if (oor) begin
        addr = ($urandom_range(0, 1) == 1) ? BASE + 32'(DEP) + $urandom_range(0, 5000)
                                           : BASE - 32'($urandom_range(1, 5000));
      end else begin
        if (!written[idx]) host_write(8'(idx), {$urandom, $urandom});
        addr = BASE + 32'(idx);
      end
      exp_d = oor ? 64'd0 : model_mem[idx];
      cw    = ($urandom_range(0, 2) == 0);
      waddr = ($urandom_range(0, 1) == 1) ? 8'(idx) : 8'($urandom_range(0, 31));
      wdata = {$urandom, $urandom};
      clr   = ($urandom_range(0, 3) == 0);
      issue_read(addr, cw, waddr, wdata, clr, lat, d, e);
      if (cw) begin model_mem[waddr] = wdata; written[waddr] = 1'b1; end
      exp_count++;
      exp_err = oor ? 1'b1 : (clr ? 1'b0 : exp_err);
      checks++; if (lat !== 2 || d !== exp_d) begin
        failures++; $display("FAIL rand_read it=%0d addr=%h got=%0d/%h exp=2/%h", it, addr, lat, d, exp_d);
      end
      checks++; if (e !== exp_err) begin failures++; $display("FAIL rand_err it=%0d got=%b exp=%b", it, e, exp_err); end
      checks++; if (rd_count !== 16'(exp_count)) begin
        failures++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, rd_count, exp_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0; int lat; logic [63:0] d; logic e;
    mem_addr = BASE + 32'd4; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 0; exp_err = 1'b0;
    if (mem_valid) beats++;
    for (int c = 0; c < 5; c++) begin
      step();
      if (mem_valid) beats++;
    end
    checks++; if (beats !== 0) begin failures++; $display("FAIL rstmid_beats got=%0d exp=0", beats); end
    checks++; if (busy !== 1'b0 || rd_count !== 16'd0) begin
      failures++; $display("FAIL rstmid_state got=%b/%0d exp=0/0", busy, rd_count);
    end
    issue_read(BASE + 32'd4, 1'b0, 8'd0, 64'd0, 1'b0, lat, d, e);
    exp_count++;
    checks++; if (lat !== 2 || d !== model_mem[4]) begin
      failures++; $display("FAIL rstmid_read got=%0d/%h exp=2/%h", lat, d, model_mem[4]);
    end
    checks++; if (rd_count !== 16'(exp_count)) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", rd_count, exp_count); end
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) begin model_mem[i] = '0; written[i] = 1'b0; end
    test_reset();
    test_burst();
    test_latency();
    test_latency_rl1();
    test_drop_read();
    test_out_of_range();
    test_read_before_write();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cgra_config_mem_responder.md
Name: cgra_config_mem_responder

Overview:
- Bitstream memory that answers the configuration loader's frame-read requests: it is the responder end of the mem_addr/mem_read/mem_rdata/mem_valid interface.
- Holds DEPTH configuration frames, written by the host/DMA through a simple write port.
- Serves one frame per request after a programmable latency, so loader sequencing can be exercised against realistic memory timing.

Parameters:
- CONFIG_WIDTH, 64, frame width in bits.
- ADDR_WIDTH, 32, loader address width.
- DEPTH, 256, number of stored frames (power of 2).
- READ_LATENCY, 2, cycles from request capture to mem_valid; legal range 1 to 15.
- BASE_ADDR, 0, loader address mapped to word 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  host write strobe
- wr_addr  in  $clog2(DEPTH)  host write word index
- wr_data  in  CONFIG_WIDTH  host write data
- mem_addr  in  ADDR_WIDTH  loader read address
- mem_read  in  1  loader read request (level)
- mem_rdata  out  CONFIG_WIDTH  returned frame
- mem_valid  out  1  one-cycle response strobe
- busy  out  1  request in flight
- rd_count  out  16  responses issued
- addr_error  out  1  sticky out-of-range flag
- err_clear  in  1  clears addr_error

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: mem_rdata=0, mem_valid=0, busy=0, rd_count=0, addr_error=0, FSM=IDLE, latency counter=0.
- Reset mid-operation discards any pending response; no mem_valid is issued for it.
- Memory array is not reset; its contents survive rst.
- FSM states:
  - IDLE: on an edge with mem_read=1, capture idx = mem_addr - BASE_ADDR (ADDR_WIDTH modular subtract).
    - If idx < DEPTH: read array[idx] into a data register.
    - Else: load 0 into the data register and flag out-of-range.
    - Load counter = READ_LATENCY-1; go to WAIT, or directly to RESP if READ_LATENCY=1.
  - WAIT: decrement counter; at 0 go to RESP.
  - RESP: mem_valid=1 and mem_rdata=captured data for exactly this cycle. rd_count increments (wraps at 0xFFFF to 0). Go to IDLE.
- Timing:
  - mem_valid is high exactly READ_LATENCY cycles after the capture edge.
  - Minimum spacing between consecutive responses is READ_LATENCY+1 cycles. The IDLE cycle after RESP lets the loader's incremented mem_addr settle before it is sampled.
- busy=1 in WAIT and RESP, 0 in IDLE.
- mem_rdata holds its last value outside RESP.
- mem_addr and mem_read are ignored outside IDLE. Dropping mem_read during WAIT does not cancel the request; the response is still issued.
- Writes:
  - wr_en writes array[wr_addr] at the edge, in any state.
  - Same-edge write and capture to the same word: the capture returns the old data (read-before-write).
  - A later write to a captured word does not alter the in-flight response.
- addr_error:
  - Set at the capture edge of an out-of-range request; the request still gets mem_valid with rdata=0, so the loader never hangs.
  - Cleared by err_clear.
  - If a set and err_clear occur on the same edge, set wins.
- rd_count counts all responses, including out-of-range ones.

Test Plan:
- Program words 0..15 with 64'hA5A5_0000_0000_0000+i. Drive a loader-style burst from mem_addr=BASE_ADDR, advancing mem_addr by 1 after each valid beat, 16 frames. Expect 16 mem_valid beats with rdata matching each word, beats 3 cycles apart (READ_LATENCY=2), and rd_count=16.
- Latency: request captured at edge E. Expect mem_valid high only in the cycle after edge E+1, busy high 2 cycles. Repeat with READ_LATENCY=1 and expect valid in the cycle after E.
- mem_addr=BASE_ADDR+DEPTH. Expect mem_valid with rdata=0 and addr_error=1. addr_error stays 1 until err_clear; err_clear on the same edge as a new out-of-range capture leaves it at 1.
- word 5=0x11, then wr_en to word 5 with 0x22 on the capture edge of addr 5. Expect rdata=0x11; the next read of word 5 returns 0x22.
- Assert rst while in WAIT. Expect no mem_valid, busy=0, rd_count=0. After reset, a new request is served normally and the array contents are intact.
- Drop mem_read the cycle after capture. Expect exactly one mem_valid beat, then FSM back in IDLE with no further beats.
